ns_sweep_ctrl: RTL and testbench



---
 rtl/ns_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_ns_sweep_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ns_sweep_ctrl.sv
// Period sweep controller for the programmable clock generator: steps ns from a
// start value to an end value, dwelling a programmed number of overflow ticks per step.
module ns_sweep_ctrl #(
   parameter int RESOLUTION  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [RESOLUTION-1:0]  ns_start,
   input  logic [RESOLUTION-1:0]  ns_step,
   input  logic [RESOLUTION-1:0]  ns_end,
   input  logic [COUNT_WIDTH-1:0] dwell,
   input  logic                   overflow,
   output logic [RESOLUTION-1:0]  ns,
   output logic                   enable,
   output logic                   step_strobe,
   output logic [RESOLUTION-1:0]  step_index,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_DWELL,
      S_ADVANCE,
      S_DONE
   } state_t;

   state_t                 state;
   logic [RESOLUTION-1:0]  step_reg;
   logic [RESOLUTION-1:0]  end_reg;
   logic [COUNT_WIDTH-1:0] dwell_last;
   logic [COUNT_WIDTH-1:0] count;

   logic [RESOLUTION:0]    next_ns;
   logic                   last_step;

   // The extra bit catches wrap-around so a sweep near the top of the range
   // terminates instead of restarting at a small period.
   assign next_ns   = {1'b0, ns} + {1'b0, step_reg};
   assign last_step = next_ns[RESOLUTION] || (next_ns[RESOLUTION-1:0] > end_reg) || (step_reg == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ns          <= '0;
         enable      <= 1'b0;
         step_strobe <= 1'b0;
         step_index  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         count       <= '0;
         step_reg    <= '0;
         end_reg     <= '0;
         dwell_last  <= '0;
      end else begin
         step_strobe <= 1'b0;
         done        <= 1'b0;
         case (state)
            S_IDLE: begin
               enable <= 1'b0;
               busy   <= 1'b0;
               if (start && !abort) begin
                  ns         <= ns_start;
                  step_index <= '0;
                  count      <= '0;
                  step_reg   <= ns_step;
                  end_reg    <= ns_end;
                  // A programmed dwell of zero behaves like one tick.
                  dwell_last <= (dwell == '0) ? '0 : dwell - COUNT_WIDTH'(1);
                  busy       <= 1'b1;
                  state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  state  <= S_IDLE;
                  enable <= 1'b0;
                  busy   <= 1'b0;
                  count  <= '0;
               end else begin
                  enable <= 1'b1;
                  state  <= S_DWELL;
               end
            end
            S_DWELL: begin
               if (abort) begin
                  state  <= S_IDLE;
                  enable <= 1'b0;
                  busy   <= 1'b0;
                  count  <= '0;
               end else if (overflow) begin
                  if (count == dwell_last) begin
                     enable      <= 1'b0;
                     step_strobe <= 1'b1;
                     count       <= '0;
                     state       <= S_ADVANCE;
                  end else begin
                     count <= count + COUNT_WIDTH'(1);
                  end
               end
            end
            S_ADVANCE: begin
               count <= '0;
               if (abort) begin
                  state  <= S_IDLE;
                  enable <= 1'b0;
                  busy   <= 1'b0;
               end else if (last_step) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  ns         <= next_ns[RESOLUTION-1:0];
                  step_index <= step_index + RESOLUTION'(1);
                  state      <= S_SETTLE;
               end
            end
            S_DONE: begin
               enable <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               enable <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ns_sweep_ctrl.sv
// Self-checking bench for ns_sweep_ctrl: table-driven sweeps, hand-written abort/reset
// sequences and randomized sweeps checked against a step-list model.
module tb_ns_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, abort, overflow;
   logic [31:0] ns_start, ns_step, ns_end;
   logic [15:0] dwell;
   logic [31:0] ns, step_index;
   logic        enable, step_strobe, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   ns_sweep_ctrl #(.RESOLUTION(32), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .ns_start(ns_start), .ns_step(ns_step), .ns_end(ns_end), .dwell(dwell),
      .overflow(overflow), .ns(ns), .enable(enable), .step_strobe(step_strobe),
      .step_index(step_index), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s;
      logic [31:0] st;
      logic [31:0] e;
      logic [15:0] dw;
      int          exp_steps;
      logic [31:0] exp_last;
   } vec_t;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives the sweep configuration and pulses start for one cycle; returns at the
   // falling edge after the edge that sampled start.
   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] st,
                                input logic [31:0] e, input logic [15:0] dw);
      @(negedge clk);
      ns_start = s; ns_step = st; ns_end = e; dwell = dw;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_ns"}, ns, 0);
      checkOutput({tag, "_enable"}, enable, 0);
      checkOutput({tag, "_strobe"}, step_strobe, 0);
      checkOutput({tag, "_index"}, step_index, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
   endtask

   // Runs one full sweep with random overflow ticks, checking every step against the
   // list of periods the rules produce.
   task automatic run_sweep(input logic [31:0] s, input logic [31:0] st, input logic [31:0] e,
                            input logic [15:0] dw, input bit poke_start,
                            output int n_steps, output logic [31:0] last_ns);
      logic [31:0] exp_q[$];
      logic [63:0] v;
      int eff, ov_cnt, k, cyc, since;
      bit fin;
      v = {32'd0, s};
      forever begin
         exp_q.push_back(v[31:0]);
         if (st == 0 || v + {32'd0, st} > {32'd0, e}) break;
         v = v + {32'd0, st};
      end
      eff = (dw == 0) ? 1 : int'(dw);
      ov_cnt = 0; k = 0; cyc = 0; since = -1; fin = 1'b0;

      applyStimulus(s, st, e, dw);
      checkOutput("lat_busy", busy, 1);
      checkOutput("lat_ns", ns, s);
      checkOutput("settle_enable", enable, 0);
      ns_step = $urandom; ns_end = $urandom; dwell = 16'($urandom);
      overflow = 1'b1;
      @(negedge clk);
      checkOutput("lat_enable", enable, 1);
      checkOutput("first_index", step_index, 0);

      while (!fin && cyc < 3000) begin
         if (since >= 0) since++;
         if (step_strobe) begin
            checkOutput("strobe_ns", ns, (k < exp_q.size()) ? exp_q[k] : 32'hDEADBEEF);
            checkOutput("strobe_index", step_index, k);
            checkOutput("strobe_dwell", ov_cnt, eff);
            checkOutput("strobe_enable", enable, 0);
            k++;
            ov_cnt = 0;
            since = 0;
         end
         if (since == 1) begin
            checkOutput("done_timing", done, (k == exp_q.size()) ? 1 : 0);
            checkOutput("post_strobe_enable", enable, 0);
         end
         if (since == 2 && k < exp_q.size()) checkOutput("reenable", enable, 1);
         if (done) begin
            checkOutput("step_count", k, exp_q.size());
            fin = 1'b1;
            last_ns = ns;
         end
         if (fin) begin
            overflow = 1'b0;
            start    = 1'b0;
         end else begin
            overflow = ($urandom_range(0, 2) == 0);
            start    = poke_start && ($urandom_range(0, 7) == 0);
            if (enable && overflow) ov_cnt++;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!fin) begin
         checkOutput("sweep_timeout", 0, 1);
         last_ns = ns;
      end
      n_steps = k;
      @(negedge clk);
      checkOutput("after_done", done, 0);
      checkOutput("after_busy", busy, 0);
      checkOutput("after_enable", enable, 0);
      checkOutput("after_ns", ns, exp_q[exp_q.size()-1]);
   endtask

   initial begin
      vec_t vecs[6];
      int n_steps;
      logic [31:0] last_ns;
      bit found;
      logic [31:0] s, st, e;
      logic [63:0] e64;

      vecs[0] = '{32'd10, 32'd10, 32'd30, 16'd2, 3, 32'd30};
      vecs[1] = '{32'd5, 32'd5, 32'd10, 16'd0, 2, 32'd10};
      vecs[2] = '{32'hFFFFFFF0, 32'h20, 32'hFFFFFFFF, 16'd1, 1, 32'hFFFFFFF0};
      vecs[3] = '{32'd7, 32'd0, 32'd100, 16'd1, 1, 32'd7};
      vecs[4] = '{32'd40, 32'd5, 32'd20, 16'd2, 1, 32'd40};
      vecs[5] = '{32'd0, 32'd3, 32'd10, 16'd3, 4, 32'd9};

      reset = 1'b1; start = 1'b1; abort = 1'b0; overflow = 1'b1;
      ns_start = 32'd99; ns_step = 32'd1; ns_end = 32'd200; dwell = 16'd1;
      repeat (3) @(negedge clk);
      checkIdleZero("reset");
      reset = 1'b0; start = 1'b0; overflow = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_sweep(vecs[i].s, vecs[i].st, vecs[i].e, vecs[i].dw, 1'b0, n_steps, last_ns);
         checkOutput($sformatf("vec%0d_steps", i), n_steps, vecs[i].exp_steps);
         checkOutput($sformatf("vec%0d_last", i), last_ns, vecs[i].exp_last);
      end

      // Abort in the dwell of the second step, then start while abort is held.
      applyStimulus(32'd10, 32'd10, 32'd30, 16'd2);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (step_index == 1 && enable) found = 1'b1;
         else begin
            overflow = ($urandom_range(0, 1) == 0);
            @(negedge clk);
         end
      end
      checkOutput("abort_reach", found, 1);
      overflow = 1'b1; abort = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_enable", enable, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_strobe", step_strobe, 0);
      checkOutput("abort_ns", ns, 20);
      checkOutput("abort_index", step_index, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("start_abort_busy", busy, 0);
      checkOutput("start_abort_ns", ns, 20);
      abort = 1'b0; overflow = 1'b0;

      // Reset while dwelling returns everything to reset values.
      applyStimulus(32'd10, 32'd10, 32'd30, 16'd2);
      for (int i = 0; i < 10 && !enable; i++) @(negedge clk);
      checkOutput("reset_reach", enable, 1);
      reset = 1'b1; overflow = 1'b1;
      @(negedge clk);
      checkIdleZero("midreset");
      reset = 1'b0; overflow = 1'b0;

      // Randomized sweeps, with stray start pulses while busy.
      for (int i = 0; i < 20; i++) begin
         s  = (($urandom_range(0, 3) == 0) ? 32'hFFFFFF80 : 32'd0) + 32'($urandom_range(0, 100));
         st = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(10, 40));
         if ($urandom_range(0, 7) == 0) e = s - 32'($urandom_range(1, 20));
         else begin
            e64 = {32'd0, s} + 64'($urandom_range(0, 150));
            e = (e64 > 64'hFFFFFFFF) ? 32'hFFFFFFFF : e64[31:0];
         end
         run_sweep(s, st, e, 16'($urandom_range(0, 3)), 1'b1, n_steps, last_ns);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
